// File: rtl/csr_birimi_pkg.sv
// Shared CSR definitions: internal target map, FS encoding, operation codes
// and the write masks used by the machine-mode CSR file.
package csr_birimi_pkg;

    typedef enum logic [1:0] {
        ISLEM_NOP = 2'b00,
        ISLEM_RW  = 2'b01,
        ISLEM_RS  = 2'b10,
        ISLEM_RC  = 2'b11
    } csr_islem_t;

    typedef enum logic [1:0] {
        FS_KAPALI    = 2'b00,
        FS_BASLANGIC = 2'b01,
        FS_TEMIZ     = 2'b10,
        FS_KIRLI     = 2'b11
    } deger_fs_t;

    typedef enum logic [4:0] {
        CSR_GECERSIZ_HEDEF,
        H_FFLAGS,
        H_FRM,
        H_FCSR,
        H_MSTATUS,
        H_MSTATUSH,
        H_MISA,
        H_MIE,
        H_MTVEC,
        H_MCOUNTINHIBIT,
        H_MSCRATCH,
        H_MEPC,
        H_MCAUSE,
        H_MTVAL,
        H_MCYCLE,
        H_MCYCLEH,
        H_MINSTRET,
        H_MINSTRETH
    } csr_hedef_t;

    localparam logic [31:0] CSR_MISA_DEGER       = 32'h4000_1120;
    localparam logic [31:0] MSTATUS_YAZ_MASKE    = 32'h0000_6088;
    localparam logic [31:0] MIE_YAZ_MASKE        = 32'h0000_0888;
    localparam logic [31:0] MCOUNTINH_YAZ_MASKE  = 32'h0000_0005;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_FS_ALT   = 13;
    localparam int MSTATUS_FS_UST   = 14;

    function automatic csr_hedef_t hedef(input logic [11:0] adres);
        case (adres)
            12'h001: return H_FFLAGS;
            12'h002: return H_FRM;
            12'h003: return H_FCSR;
            12'h300: return H_MSTATUS;
            12'h301: return H_MISA;
            12'h304: return H_MIE;
            12'h305: return H_MTVEC;
            12'h310: return H_MSTATUSH;
            12'h320: return H_MCOUNTINHIBIT;
            12'h340: return H_MSCRATCH;
            12'h341: return H_MEPC;
            12'h342: return H_MCAUSE;
            12'h343: return H_MTVAL;
            12'hB00: return H_MCYCLE;
            12'hB02: return H_MINSTRET;
            12'hB80: return H_MCYCLEH;
            12'hB82: return H_MINSTRETH;
            default: return CSR_GECERSIZ_HEDEF;
        endcase
    endfunction

    // Only the two states the core tracks are kept; 01/10 collapse to off.
    function automatic deger_fs_t fs_coz(input logic [1:0] ham);
        return (ham == 2'b11) ? FS_KIRLI : FS_KAPALI;
    endfunction

endpackage

// File: rtl/csr_birimi_sayac64.sv
// 64-bit event counter with inhibit, increment enable and per-half load.
module csr_sayac64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inhibit_i,
    input  logic        artir_i,
    input  logic        yaz_alt_i,
    input  logic        yaz_ust_i,
    input  logic [31:0] veri_i,
    output logic [63:0] deger_o
);

    logic [63:0] sayac_q, sayac_d;

    always_comb begin
        sayac_d = sayac_q;
        if (yaz_alt_i)
            sayac_d[31:0] = veri_i;
        else if (yaz_ust_i)
            sayac_d[63:32] = veri_i;
        else if (artir_i && !inhibit_i)
            sayac_d = sayac_q + 64'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            sayac_q <= '0;
        else
            sayac_q <= sayac_d;
    end

    assign deger_o = sayac_q;

endmodule

// File: rtl/csr_birimi.sv
// Machine-mode CSR file: FP CSRs, trap/return state, cycle and instret.
module csr_birimi
    import csr_birimi_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        istek_gecerli_i,
    input  logic [11:0] istek_adres_i,
    input  logic [1:0]  istek_islem_i,
    input  logic        istek_yaz_i,
    input  logic [31:0] istek_veri_i,
    output logic [31:0] oku_veri_o,
    output logic        gecersiz_o,
    input  logic        fflags_gecerli_i,
    input  logic [4:0]  fflags_i,
    input  logic        emekli_i,
    input  logic        tuzak_i,
    input  logic [31:0] tuzak_pc_i,
    input  logic [31:0] tuzak_sebep_i,
    input  logic [31:0] tuzak_deger_i,
    input  logic        mret_i,
    output logic [31:0] tuzak_hedef_o,
    output logic [31:0] mepc_o,
    output logic [2:0]  frm_o,
    output logic [1:0]  fs_o,
    output logic        mstatus_mie_o,
    output logic [31:0] mie_o
);

    deger_fs_t   fs_q, fs_d;
    logic        mie_bit_q, mie_bit_d;
    logic        mpie_q, mpie_d;
    logic [4:0]  fflags_q, fflags_d;
    logic [2:0]  frm_q, frm_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic        inh_cy_q, inh_cy_d;
    logic        inh_ir_q, inh_ir_d;

    csr_hedef_t  hedef_w;
    csr_islem_t  islem_w;
    logic        fp_hedef;
    logic        yaz_en;
    logic [31:0] eski, yeni, mstatus_oku;
    logic [63:0] mcycle_w, minstret_w;
    logic [31:0] taban;

    assign hedef_w  = hedef(istek_adres_i);
    assign islem_w  = csr_islem_t'(istek_islem_i);
    assign fp_hedef = (hedef_w == H_FFLAGS) || (hedef_w == H_FRM) ||
                      (hedef_w == H_FCSR);
    assign gecersiz_o = (hedef_w == CSR_GECERSIZ_HEDEF) ||
                        (fp_hedef && fs_q == FS_KAPALI);
    assign yaz_en = istek_gecerli_i && istek_yaz_i && islem_w != ISLEM_NOP &&
                    !gecersiz_o && !tuzak_i && !mret_i;

    assign mstatus_oku = {fs_q == FS_KIRLI, 16'b0, fs_q, 2'b11, 3'b0,
                          mpie_q, 3'b0, mie_bit_q, 3'b0};

    always_comb begin
        eski = '0;
        unique case (hedef_w)
            H_FFLAGS:        eski = {27'b0, fflags_q};
            H_FRM:           eski = {29'b0, frm_q};
            H_FCSR:          eski = {24'b0, frm_q, fflags_q};
            H_MSTATUS:       eski = mstatus_oku;
            H_MISA:          eski = CSR_MISA_DEGER;
            H_MIE:           eski = mie_q;
            H_MTVEC:         eski = mtvec_q;
            H_MCOUNTINHIBIT: eski = {29'b0, inh_ir_q, 1'b0, inh_cy_q};
            H_MSCRATCH:      eski = mscratch_q;
            H_MEPC:          eski = mepc_q;
            H_MCAUSE:        eski = mcause_q;
            H_MTVAL:         eski = mtval_q;
            H_MCYCLE:        eski = mcycle_w[31:0];
            H_MCYCLEH:       eski = mcycle_w[63:32];
            H_MINSTRET:      eski = minstret_w[31:0];
            H_MINSTRETH:     eski = minstret_w[63:32];
            default:         eski = '0;
        endcase
    end

    always_comb begin
        yeni = eski;
        unique case (islem_w)
            ISLEM_RW: yeni = istek_veri_i;
            ISLEM_RS: yeni = eski | istek_veri_i;
            ISLEM_RC: yeni = eski & ~istek_veri_i;
            default:  yeni = eski;
        endcase
    end

    always_comb begin
        fs_d       = fs_q;
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        fflags_d   = fflags_q;
        frm_d      = frm_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        inh_cy_d   = inh_cy_q;
        inh_ir_d   = inh_ir_q;
        if (yaz_en) begin
            unique case (hedef_w)
                H_FFLAGS: fflags_d = yeni[4:0];
                H_FRM:    frm_d = yeni[2:0];
                H_FCSR: begin
                    frm_d    = yeni[7:5];
                    fflags_d = yeni[4:0];
                end
                H_MSTATUS: begin
                    mie_bit_d = yeni[MSTATUS_MIE_BIT];
                    mpie_d    = yeni[MSTATUS_MPIE_BIT];
                    fs_d      = fs_coz(yeni[MSTATUS_FS_UST:MSTATUS_FS_ALT]);
                end
                H_MIE:      mie_d = yeni & MIE_YAZ_MASKE;
                H_MTVEC:    mtvec_d = {yeni[31:2], 1'b0, yeni[0]};
                H_MSCRATCH: mscratch_d = yeni;
                H_MEPC:     mepc_d = {yeni[31:2], 2'b00};
                H_MCAUSE:   mcause_d = yeni;
                H_MTVAL:    mtval_d = yeni;
                H_MCOUNTINHIBIT: begin
                    inh_cy_d = yeni[0];
                    inh_ir_d = yeni[2];
                end
                default: ;
            endcase
            if (fp_hedef)
                fs_d = FS_KIRLI;
        end
        // FPU flags accumulate on top of any same-cycle software write.
        if (fflags_gecerli_i) begin
            fflags_d = fflags_d | fflags_i;
            fs_d     = FS_KIRLI;
        end
        if (tuzak_i) begin
            mepc_d    = {tuzak_pc_i[31:2], 2'b00};
            mcause_d  = tuzak_sebep_i;
            mtval_d   = tuzak_deger_i;
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
        end else if (mret_i) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fs_q       <= FS_KAPALI;
            mie_bit_q  <= 1'b0;
            mpie_q     <= 1'b0;
            fflags_q   <= '0;
            frm_q      <= '0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            inh_cy_q   <= 1'b0;
            inh_ir_q   <= 1'b0;
        end else begin
            fs_q       <= fs_d;
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            fflags_q   <= fflags_d;
            frm_q      <= frm_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            inh_cy_q   <= inh_cy_d;
            inh_ir_q   <= inh_ir_d;
        end
    end

    csr_sayac64 u_mcycle (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inhibit_i (inh_cy_q),
        .artir_i   (1'b1),
        .yaz_alt_i (yaz_en && hedef_w == H_MCYCLE),
        .yaz_ust_i (yaz_en && hedef_w == H_MCYCLEH),
        .veri_i    (yeni),
        .deger_o   (mcycle_w)
    );

    csr_sayac64 u_minstret (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inhibit_i (inh_ir_q),
        .artir_i   (emekli_i),
        .yaz_alt_i (yaz_en && hedef_w == H_MINSTRET),
        .yaz_ust_i (yaz_en && hedef_w == H_MINSTRETH),
        .veri_i    (yeni),
        .deger_o   (minstret_w)
    );

    // Vectored mode only offsets interrupts; exceptions use the base.
    assign taban = {mtvec_q[31:2], 2'b00};
    assign tuzak_hedef_o = (mtvec_q[0] && tuzak_sebep_i[31]) ?
                           taban + {25'b0, tuzak_sebep_i[4:0], 2'b00} : taban;

    assign oku_veri_o    = eski;
    assign mepc_o        = mepc_q;
    assign frm_o         = frm_q;
    assign fs_o          = fs_q;
    assign mstatus_mie_o = mie_bit_q;
    assign mie_o         = mie_q;

endmodule

// File: doc/csr_birimi.md
# csr_birimi

Machine-mode control and status register file of the core; consumes the CSR internal-target mapping and FS encoding helpers from the shared CSR package. Executes CSRRW/CSRRS/CSRRC reads and writes from the execute stage, holds the FP CSRs, trap/return state and 64-bit cycle/instret counters. Supplies the trap vector, mepc, frm and FS to the fetch, control and FPU stages.

## Interface

- No parameters; MISA value and write masks are package constants.
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- istek_gecerli_i  in  1  CSR instruction valid this cycle
- istek_adres_i  in  12  CSR address
- istek_islem_i  in  2  01 RW, 10 RS, 11 RC, 00 no-op
- istek_yaz_i  in  1  write intent (0 for RS/RC with rs1=x0)
- istek_veri_i  in  32  rs1 value or zimm
- oku_veri_o  out  32  old CSR value, combinational
- gecersiz_o  out  1  illegal access, combinational
- fflags_gecerli_i  in  1  FPU reports exception flags
- fflags_i  in  5  flags to OR into fflags
- emekli_i  in  1  one instruction retired
- tuzak_i, tuzak_pc_i[31:0], tuzak_sebep_i[31:0], tuzak_deger_i[31:0]  in  trap entry, PC, mcause, mtval
- mret_i  in  1  MRET executes
- tuzak_hedef_o  out  32  trap target PC
- mepc_o  out  32  MRET return PC
- frm_o  out  3; fs_o  out  2; mstatus_mie_o  out  1; mie_o  out  32

## Operation

- Address decoded with package `hedef`; CSR_GECERSIZ_HEDEF asserts gecersiz_o, no state change.
- FCSR/FRM/FFLAGS while FS=FS_KAPALI: gecersiz_o=1, no state change.
- New value: RW = veri; RS = old | veri; RC = old & ~veri; committed only if istek_yaz_i and not gecersiz_o.
- Write rules: MISA read-only constant 0x40001120 (RV32IMF), writes ignored, no error. MSTATUSH reads 0, writes ignored. MSTATUS writable MIE[3], MPIE[7], FS[14:13] via `deger_fs_t` (01/10 -> KAPALI); MPP[12:11] reads 11; SD[31] = (FS==KIRLI). MIE mask 0x888. MTVEC bit1 forced 0 (mode 0 direct, 1 vectored). MEPC [1:0] forced 0. MCOUNTINHIBIT mask 0x5. MCAUSE, MTVAL, MSCRATCH full 32 bits.
- FCSR read {24'b0,frm,fflags}; any write to FCSR/FRM/FFLAGS or fflags_gecerli_i sets FS to KIRLI.
- fflags_gecerli_i ORs fflags_i into fflags; a same-cycle CSR write to fflags/fcsr wins, then the FPU flags are ORed on top.
- Trap (tuzak_i): mepc<=tuzak_pc_i&~3, mcause<=tuzak_sebep_i, mtval<=tuzak_deger_i, MPIE<=MIE, MIE<=0. Any same-cycle CSR write is dropped.
- MRET (mret_i, no tuzak_i): MIE<=MPIE, MPIE<=1. Priority: tuzak_i > mret_i > CSR write.
- tuzak_hedef_o: mode 0 or synchronous cause -> base {mtvec[31:2],2'b00}; mode 1 and mcause bit31 set -> base + 4*tuzak_sebep_i[4:0].
- mcycle increments every cycle unless mcountinhibit[0]; minstret increments on emekli_i unless mcountinhibit[2]. 64-bit, wrap 0xFFFF_FFFF_FFFF_FFFF -> 0, carry low->high in the same cycle.
- A write to either half of a counter loads that half, holds the other half and suppresses that counter's increment that cycle.

## Timing

- Reads and gecersiz_o are combinational with istek; read returns the pre-edge value (mcycle returns the value before this cycle's increment).
- All writes, trap and MRET updates take effect on the next rising edge; a following-cycle read sees the new value.
- Reset: all registers 0, FS=KAPALI, MPP reads 11, MISA constant. Outputs after reset: oku_veri_o per address, gecersiz_o per decode, tuzak_hedef_o=0, mepc_o=0, frm_o=0, fs_o=00, mstatus_mie_o=0, mie_o=0.
- Reset asserted mid-operation clears state immediately, including counters.

## Structure

- Package additions: csr_islem_t (NOP/RW/RS/RC), CSR_MISA_DEGER, write masks for MSTATUS/MIE/MCOUNTINHIBIT, mstatus bit positions.
- Sub-module csr_sayac64: 64-bit counter with inhibit, increment enable and per-half write; instantiated for mcycle and minstret.

## Test plan

- Reset, read MISA -> 0x40001120; read MSTATUS -> 0x00001800; CSRRW MISA 0 -> still 0x40001120, gecersiz_o=0.
- CSRRW FCSR with FS=00 -> gecersiz_o=1; set FS=11, CSRRS FFLAGS 0x3, then fflags_i=0x4 -> FCSR reads 0x07, MSTATUS SD=1.
- MTVEC=0x1001, tuzak_i with sebep 0x8000_0007, pc 0x200 -> tuzak_hedef_o=0x101C, mepc=0x200, MIE 1->0, MPIE=1; mret_i -> MIE=1.
- tuzak_i and CSRRW MSCRATCH=0xAA in the same cycle -> MSCRATCH unchanged.
- MCYCLE=0xFFFF_FFFF, MCYCLEH=0 -> after two cycles MCYCLEH=1, MCYCLE=0x0000_0000 then 0x1; MCOUNTINHIBIT=1 -> MCYCLE frozen.
- Unmapped address 0x7C0 -> gecersiz_o=1, no register changes.
